// File: rtl/avalon_clint_pkg.sv
// avalon_clint_pkg: Avalon-MM bus types, CLINT register offsets and byte-enable merge
package avalon_clint_pkg;
  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byte_enable;
  } avalon_req_t;
  typedef struct packed {
    logic [31:0] readdata;
    logic        waitrequest;
  } avalon_resp_t;
  localparam logic [15:0] CLINT_MSIP_OFF        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI_OFF    = 16'hBFFC;
  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~m) | (wd & m);
  endfunction
endpackage

// File: rtl/avalon_clint_timer.sv
// avalon_clint_timer: prescaled 64-bit mtime, mtimecmp and registered timer compare
module avalon_clint_timer #(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mtime_we,
  input  logic [1:0]  cmp_we,
  input  logic [31:0] wdata,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        irq
);
  logic [15:0] prescaler;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      prescaler <= '0;
      mtime <= '0;
    end else if (|mtime_we) begin
      prescaler <= '0;
      if (mtime_we[0]) mtime[31:0] <= wdata;
      if (mtime_we[1]) mtime[63:32] <= wdata;
    end else if (prescaler == 16'(TICK_DIV - 1)) begin
      prescaler <= '0;
      mtime <= mtime + 64'd1;
    end else begin
      prescaler <= prescaler + 16'd1;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mtimecmp <= '1;
    end else begin
      if (cmp_we[0]) mtimecmp[31:0] <= wdata;
      if (cmp_we[1]) mtimecmp[63:32] <= wdata;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) irq <= 1'b0;
    else irq <= mtime >= mtimecmp;
endmodule

// File: rtl/avalon_clint.sv
// avalon_clint: Avalon-MM RISC-V CLINT with msip, mtimecmp and coherent mtime reads
module avalon_clint
  import avalon_clint_pkg::*;
#(
  parameter int AW       = 16,
  parameter int TICK_DIV = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  avalon_req_t  avn_req,
  output avalon_resp_t avn_resp,
  output logic         software_interrupt,
  output logic         timer_interrupt
);
  localparam logic IDLE = 1'b0;
  localparam logic RESP = 1'b1;
  logic          state, msip, shadow_valid, wr, rd, unused_bits;
  logic          sel_msip, sel_cmp_lo, sel_cmp_hi, sel_lo, sel_hi;
  logic [31:0]   shadow, readdata, cur, merged;
  logic [63:0]   mtime, mtimecmp;
  logic [AW-1:0] off;
  assign off         = {avn_req.address[AW-1:2], 2'b00};
  assign unused_bits = ^{avn_req.address[31:AW], avn_req.address[1:0]};
  assign sel_msip    = off == AW'(CLINT_MSIP_OFF);
  assign sel_cmp_lo  = off == AW'(CLINT_MTIMECMP_LO_OFF);
  assign sel_cmp_hi  = off == AW'(CLINT_MTIMECMP_HI_OFF);
  assign sel_lo      = off == AW'(CLINT_MTIME_LO_OFF);
  assign sel_hi      = off == AW'(CLINT_MTIME_HI_OFF);
  assign wr          = avn_req.write && |avn_req.byte_enable;
  assign rd          = state == IDLE && avn_req.read && !avn_req.write;
  always_comb begin
    cur = sel_msip ? {31'd0, msip} :
          sel_cmp_lo ? mtimecmp[31:0] :
          sel_cmp_hi ? mtimecmp[63:32] :
          sel_lo ? mtime[31:0] :
          sel_hi ? mtime[63:32] : 32'd0;
    merged = be_merge(cur, avn_req.writedata, avn_req.byte_enable);
  end
  avalon_clint_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .mtime_we ({wr && sel_hi, wr && sel_lo}),
    .cmp_we   ({wr && sel_cmp_hi, wr && sel_cmp_lo}),
    .wdata    (merged),
    .mtime    (mtime),
    .mtimecmp (mtimecmp),
    .irq      (timer_interrupt)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      readdata <= '0;
      shadow <= '0;
      shadow_valid <= 1'b0;
      msip <= 1'b0;
    end else begin
      state <= rd ? RESP : IDLE;
      if (rd) readdata <= sel_hi && shadow_valid ? shadow : cur;
      if (rd && sel_lo) begin
        shadow <= mtime[63:32];
        shadow_valid <= 1'b1;
      end
      if (rd && sel_hi) shadow_valid <= 1'b0;
      if (wr && sel_msip) msip <= merged[0];
    end
  assign software_interrupt = msip;
  assign avn_resp = '{readdata: readdata, waitrequest: rst && rd};
endmodule

// File: tb/tb_avalon_clint.sv
// tb_avalon_clint: directed vector and sequence checks of avalon_clint
module tb_avalon_clint;
  import avalon_clint_pkg::*;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_sw;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0, rst4 = 1'b0;
  avalon_req_t req = '0, req4 = '0;
  avalon_resp_t resp, resp4;
  logic sw, ti, sw4, ti4;
  int n_cmp = 0, n_err = 0;
  vec_t tbl[12];
  logic [31:0] d;
  always #5 clk = ~clk;
  avalon_clint dut (
    .clk(clk), .rst(rst), .avn_req(req), .avn_resp(resp),
    .software_interrupt(sw), .timer_interrupt(ti)
  );
  avalon_clint #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst4), .avn_req(req4), .avn_resp(resp4),
    .software_interrupt(sw4), .timer_interrupt(ti4)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic wr(input int u, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    if (u == 0) begin
      req.write = 1'b1; req.address = a; req.writedata = wd; req.byte_enable = be;
    end else begin
      req4.write = 1'b1; req4.address = a; req4.writedata = wd; req4.byte_enable = be;
    end
    @(negedge clk);
    req.write = 1'b0;
    req4.write = 1'b0;
  endtask
  task automatic rd(input int u, input logic [31:0] a, output logic [31:0] q);
    if (u == 0) begin
      req.read = 1'b1; req.address = a;
    end else begin
      req4.read = 1'b1; req4.address = a;
    end
    #1 chk("rd_wait_req", 32'(u == 0 ? resp.waitrequest : resp4.waitrequest), 32'd1);
    @(negedge clk);
    chk("rd_wait_resp", 32'(u == 0 ? resp.waitrequest : resp4.waitrequest), 32'd0);
    q = u == 0 ? resp.readdata : resp4.readdata;
    req.read = 1'b0;
    req4.read = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal;
  end
  initial begin
    tbl[0]  = '{32'h0000_0000, 32'h0000_0001, 4'b0010, 32'h0000_0000, 1'b0};
    tbl[1]  = '{32'h0000_0000, 32'h0000_0001, 4'b0001, 32'h0000_0001, 1'b1};
    tbl[2]  = '{32'h0000_0000, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0001, 1'b1};
    tbl[3]  = '{32'h0000_0000, 32'h0000_0000, 4'b0000, 32'h0000_0001, 1'b1};
    tbl[4]  = '{32'h0000_0000, 32'h0000_0000, 4'b1111, 32'h0000_0000, 1'b0};
    tbl[5]  = '{32'h0000_4004, 32'h1234_5678, 4'b1111, 32'h1234_5678, 1'b0};
    tbl[6]  = '{32'h0000_4004, 32'h0000_00AB, 4'b0001, 32'h1234_56AB, 1'b0};
    tbl[7]  = '{32'h0000_4000, 32'h1122_3344, 4'b1111, 32'h1122_3344, 1'b0};
    tbl[8]  = '{32'h0000_4000, 32'hAABB_CCDD, 4'b0101, 32'h11BB_33DD, 1'b0};
    tbl[9]  = '{32'h0000_1234, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 1'b0};
    tbl[10] = '{32'h0000_4003, 32'h0000_0055, 4'b1111, 32'h0000_0055, 1'b0};
    tbl[11] = '{32'h0001_4004, 32'h0000_0009, 4'b1111, 32'h0000_0009, 1'b0};
    req.read = 1'b1;
    #1;
    chk("reset_wait", 32'(resp.waitrequest), 32'd0);
    chk("reset_rdata", resp.readdata, 32'd0);
    chk("reset_ti", 32'(ti), 32'd0);
    chk("reset_sw", 32'(sw), 32'd0);
    req.read = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    rd(0, 32'hBFF8, d);
    chk("idle10_mtime_lo", d, 32'h0000_000A);
    chk("idle_ti", 32'(ti), 32'd0);
    chk("idle_sw", 32'(sw), 32'd0);
    rd(0, 32'h4000, d);
    chk("reset_cmp_lo", d, 32'hFFFF_FFFF);
    rd(0, 32'h4004, d);
    chk("reset_cmp_hi", d, 32'hFFFF_FFFF);
    for (int i = 0; i < 12; i++) begin
      wr(0, tbl[i].addr, tbl[i].wdata, tbl[i].be);
      chk($sformatf("tbl%0d_sw", i), 32'(sw), 32'(tbl[i].exp_sw));
      rd(0, tbl[i].addr, d);
      chk($sformatf("tbl%0d_rd", i), d, tbl[i].exp_rd);
    end
    wr(0, 32'h4004, 32'h0, 4'hF);
    wr(0, 32'h4000, 32'h20, 4'hF);
    wr(0, 32'hBFFC, 32'h0, 4'hF);
    wr(0, 32'hBFF8, 32'h10, 4'hF);
    repeat (16) @(negedge clk);
    chk("ti_before_match", 32'(ti), 32'd0);
    @(negedge clk);
    chk("ti_rise", 32'(ti), 32'd1);
    wr(0, 32'h4000, 32'hFFFF_FFFF, 4'hF);
    chk("ti_hold_after_cmp_write", 32'(ti), 32'd1);
    @(negedge clk);
    chk("ti_fall", 32'(ti), 32'd0);
    wr(0, 32'hBFFC, 32'h0, 4'hF);
    wr(0, 32'hBFF8, 32'hFFFF_FFFE, 4'hF);
    rd(0, 32'hBFF8, d);
    chk("carry_lo", d, 32'hFFFF_FFFE);
    rd(0, 32'hBFFC, d);
    chk("carry_hi_shadow", d, 32'h0);
    rd(0, 32'hBFFC, d);
    chk("carry_hi_live", d, 32'h1);
    req.read = 1'b1;
    req.address = 32'h0;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("b2b_wait%0d", k), 32'(resp.waitrequest), 32'(k % 2 == 0));
      @(negedge clk);
    end
    req.read = 1'b0;
    req.write = 1'b1;
    req.read = 1'b1;
    req.writedata = 32'h1;
    req.byte_enable = 4'b0001;
    #1 chk("rw_wait", 32'(resp.waitrequest), 32'd0);
    @(negedge clk);
    chk("rw_sw", 32'(sw), 32'd1);
    req.read = 1'b0;
    req.write = 1'b0;
    rd(0, 32'h0, d);
    chk("rw_msip", d, 32'h1);
    rst4 = 1'b1;
    repeat (8) @(negedge clk);
    rd(1, 32'hBFF8, d);
    chk("div4_mtime_2", d, 32'h2);
    repeat (2) @(negedge clk);
    rd(1, 32'hBFF8, d);
    chk("div4_mtime_3", d, 32'h3);
    wr(1, 32'h4004, 32'h0, 4'hF);
    wr(1, 32'h4000, 32'h0, 4'hF);
    @(negedge clk);
    chk("div4_ti", 32'(ti4), 32'd1);
    req4.read = 1'b1;
    req4.address = 32'hBFF8;
    @(negedge clk);
    chk("div4_resp_rdata", resp4.readdata, 32'h4);
    rst4 = 1'b0;
    req4.read = 1'b0;
    #1;
    chk("midrst_wait", 32'(resp4.waitrequest), 32'd0);
    chk("midrst_rdata", resp4.readdata, 32'd0);
    chk("midrst_ti", 32'(ti4), 32'd0);
    @(negedge clk);
    rst4 = 1'b1;
    rd(1, 32'hBFF8, d);
    chk("midrst_mtime", d, 32'h0);
    rd(1, 32'h4000, d);
    chk("midrst_cmp_lo", d, 32'hFFFF_FFFF);
    rd(1, 32'h4004, d);
    chk("midrst_cmp_hi", d, 32'hFFFF_FFFF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
